elevador_n_pisos: RTL and testbench

//  Parametrised elevator controller for N floors. It latches per-floor call requests and runs a SCAN
//  (keep-direction) dispatcher. It moves the car one floor per step tick and animates a two-leaf door
//  on izqLed/derLed: open, hold, close. Single clock domain; an internal step-tick counter replaces
//  the external clock divider. Inputs arrive already debounced/one-shot from debouncer_oneshot.

---
 rtl/elevador_pkg.sv | 26 ++
 rtl/step_tick.sv | 26 ++
 rtl/elevador_n_pisos.sv | 156 +++++++++++++++
 tb/tb_elevador_n_pisos.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// rtl/elevador_pkg.sv - state encoding and door LED helpers shared by the elevator controller
package elevador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_OPEN  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CLOSE = 3'd4
    } elev_state_t;

    localparam int unsigned LED_MAX = 32;

    function automatic logic [LED_MAX-1:0] led_ones(input int unsigned w);
        led_ones = (w >= LED_MAX) ? '1 : ((LED_MAX'(1) << w) - LED_MAX'(1));
    endfunction

    function automatic logic [LED_MAX-1:0] led_fill(input int unsigned w, input logic v);
        led_fill = v ? led_ones(w) : '0;
    endfunction

    function automatic logic [LED_MAX-1:0] led_msb(input int unsigned w);
        led_msb = LED_MAX'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/step_tick.sv
// rtl/step_tick.sv - free-running divider producing a one-clk step tick every STEP_DIV cycles
module step_tick #(
    parameter int STEP_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_a_p,
    output logic tick
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/elevador_n_pisos.sv
// rtl/elevador_n_pisos.sv - N-floor SCAN elevator controller with two-leaf door animation
// Optional obstruction sensor input and behaviour enabled by defining ELEV_OBSTRUCT_EN.
module elevador_n_pisos
    import elevador_pkg::*;
#(
    parameter int FLOORS    = 5,
    parameter int LED_W     = 5,
    parameter int STEP_DIV  = 25000000,
    parameter int DOOR_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst_a_p,
    input  logic [FLOORS-1:0]          call_req,
`ifdef ELEV_OBSTRUCT_EN
    input  logic                       obstruct,
`endif
    output logic [$clog2(FLOORS)-1:0]  floor,
    output logic [LED_W-1:0]           izqLed,
    output logic [LED_W-1:0]           derLed,
    output logic                       moving,
    output logic                       dir_up,
    output logic [FLOORS-1:0]          pending
);
    localparam int FW = $clog2(FLOORS);
    localparam int HW = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
    localparam logic [FW-1:0]    TOP_FLOOR = FW'(FLOORS - 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(DOOR_HOLD - 1);
    localparam logic [LED_W-1:0] LED_ONES  = LED_W'(led_ones(LED_W));
    localparam logic [LED_W-1:0] LED_ZEROS = LED_W'(led_fill(LED_W, 1'b0));
    localparam logic [LED_W-1:0] LED_MSB   = LED_W'(led_msb(LED_W));

    elev_state_t       state, state_n;
    logic [FW-1:0]     floor_n, arr;
    logic [LED_W-1:0]  izq_n, der_n;
    logic              dir_n;
    logic [HW-1:0]     hold_cnt, hold_n;
    logic [FLOORS-1:0] clr;
    logic              tick, obs;

    step_tick #(.STEP_DIV(STEP_DIV)) u_step_tick (
        .clk     (clk),
        .rst_a_p (rst_a_p),
        .tick    (tick)
    );

`ifdef ELEV_OBSTRUCT_EN
    assign obs = obstruct;
`else
    assign obs = 1'b0;
`endif

    function automatic logic calls_ahead(input logic [FLOORS-1:0] p, input logic [FW-1:0] f,
                                         input logic up);
        calls_ahead = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) calls_ahead = 1'b1;
        end
    endfunction

    always_comb begin
        state_n = state;
        floor_n = floor;
        izq_n   = izqLed;
        der_n   = derLed;
        dir_n   = dir_up;
        hold_n  = hold_cnt;
        clr     = '0;
        arr     = floor;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    izq_n = LED_ONES;
                    der_n = LED_ONES;
                    if (pending[floor]) begin
                        state_n    = ST_OPEN;
                        clr[floor] = 1'b1;
                    end else if (calls_ahead(pending, floor, dir_up)) begin
                        state_n = ST_MOVE;
                    end else if (calls_ahead(pending, floor, !dir_up)) begin
                        state_n = ST_MOVE;
                        dir_n   = !dir_up;
                    end
                end
                ST_MOVE: begin
                    // Saturating step keeps the car inside 0..FLOORS-1 even if the call set changes.
                    if (dir_up && floor != TOP_FLOOR) arr = floor + FW'(1);
                    else if (!dir_up && floor != '0) arr = floor - FW'(1);
                    floor_n = arr;
                    if (pending[arr]) begin
                        state_n  = ST_OPEN;
                        clr[arr] = 1'b1;
                    end else if (calls_ahead(pending, arr, dir_up)) begin
                        state_n = ST_MOVE;
                    end else if (calls_ahead(pending, arr, !dir_up)) begin
                        dir_n = !dir_up;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_OPEN: begin
                    izq_n = izqLed << 1;
                    der_n = derLed >> 1;
                    if (izq_n == LED_ZEROS && der_n == LED_ZEROS) begin
                        state_n = ST_HOLD;
                        hold_n  = '0;
                    end
                end
                ST_HOLD: begin
                    if (pending[floor] || obs) begin
                        hold_n     = '0;
                        clr[floor] = pending[floor];
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_n = ST_CLOSE;
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end
                ST_CLOSE: begin
                    // Reopening keeps the partial leaf pattern; OPEN resumes shifting from it.
                    if (obs) begin
                        state_n    = ST_OPEN;
                        clr[floor] = 1'b1;
                    end else begin
                        izq_n = (izqLed >> 1) | LED_MSB;
                        der_n = (derLed << 1) | LED_W'(1);
                        if (izq_n == LED_ONES && der_n == LED_ONES) state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            state    <= ST_IDLE;
            floor    <= '0;
            izqLed   <= LED_ONES;
            derLed   <= LED_ONES;
            dir_up   <= 1'b1;
            moving   <= 1'b0;
            hold_cnt <= '0;
            pending  <= '0;
        end else begin
            state    <= state_n;
            floor    <= floor_n;
            izqLed   <= izq_n;
            derLed   <= der_n;
            dir_up   <= dir_n;
            moving   <= (state_n == ST_MOVE);
            hold_cnt <= hold_n;
            pending  <= (pending | call_req) & ~clr;
        end
    end

endmodule

// File: tb/tb_elevador_n_pisos.sv
// tb/tb_elevador_n_pisos.sv - scoreboard bench for elevador_n_pisos against a tick-level reference model
module tb_elevador_n_pisos;
    localparam int FLOORS = 5, LED_W = 5, STEP_DIV = 4, DOOR_HOLD = 2;
    localparam int FW = $clog2(FLOORS);
    localparam logic [LED_W-1:0] ONES = '1;
    localparam int S_IDLE = 0, S_MOVE = 1, S_OPEN = 2, S_HOLD = 3, S_CLOSE = 4;

    typedef struct packed {
        logic [FW-1:0]     fl;
        logic [LED_W-1:0]  izq;
        logic [LED_W-1:0]  der;
        logic              mov;
        logic              up;
        logic [FLOORS-1:0] pend;
    } snap_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_p, rst1;
    logic [FLOORS-1:0] call_req, call_req1;
    logic [FW-1:0] floor, floor1;
    logic [LED_W-1:0] izqLed, derLed, izq1, der1;
    logic moving, dir_up, moving1, dir1;
    logic [FLOORS-1:0] pending, pending1;
`ifdef ELEV_OBSTRUCT_EN
    logic obstruct, obstruct1;
`endif

    elevador_n_pisos #(.FLOORS(FLOORS), .LED_W(LED_W), .STEP_DIV(STEP_DIV), .DOOR_HOLD(DOOR_HOLD)) dut (
        .clk(clk), .rst_a_p(rst_a_p), .call_req(call_req),
`ifdef ELEV_OBSTRUCT_EN
        .obstruct(obstruct),
`endif
        .floor(floor), .izqLed(izqLed), .derLed(derLed), .moving(moving), .dir_up(dir_up),
        .pending(pending)
    );

    elevador_n_pisos #(.FLOORS(FLOORS), .LED_W(LED_W), .STEP_DIV(1), .DOOR_HOLD(DOOR_HOLD)) dut1 (
        .clk(clk), .rst_a_p(rst1), .call_req(call_req1),
`ifdef ELEV_OBSTRUCT_EN
        .obstruct(obstruct1),
`endif
        .floor(floor1), .izqLed(izq1), .derLed(der1), .moving(moving1), .dir_up(dir1),
        .pending(pending1)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_chk = 0, n_fail = 0;
    bit mon_en = 0;
    snap_t mon_prev, last_exp;
    snap_t exp_q[$];
    int    exp_e[$];

    int m_state, m_floor, m_open, m_hold, m_cnt;
    bit m_up;
    bit [FLOORS-1:0] m_pend;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", nm, act, req, edge_cnt);
        end
    endtask

    function automatic snap_t take_snap();
        take_snap = '{fl: floor, izq: izqLed, der: derLed, mov: moving, up: dir_up, pend: pending};
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.fl   = FW'(m_floor);
        s.izq  = ONES << m_open;
        s.der  = ONES >> m_open;
        s.mov  = (m_state == S_MOVE);
        s.up   = m_up;
        s.pend = m_pend;
        return s;
    endfunction

    function automatic bit m_ahead(int f, bit up);
        for (int i = 0; i < FLOORS; i++)
            if (m_pend[i] && (up ? i > f : i < f)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_floor = 0; m_open = 0; m_hold = 0; m_cnt = 0; m_up = 1; m_pend = '0;
    endtask

    // m_open counts removed leaf segments: 0 = door shut, LED_W = fully open.
    task automatic model_edge(input logic [FLOORS-1:0] c, input bit o, input int e);
        bit [FLOORS-1:0] clr;
        snap_t s;
        clr = '0;
        if (m_cnt == STEP_DIV - 1) begin
            m_cnt = 0;
            case (m_state)
                S_IDLE: begin
                    if (m_pend[m_floor]) begin m_state = S_OPEN; clr[m_floor] = 1; end
                    else if (m_ahead(m_floor, m_up)) m_state = S_MOVE;
                    else if (m_ahead(m_floor, !m_up)) begin m_up = !m_up; m_state = S_MOVE; end
                end
                S_MOVE: begin
                    m_floor += m_up ? 1 : -1;
                    if (m_pend[m_floor]) begin m_state = S_OPEN; clr[m_floor] = 1; end
                    else if (m_ahead(m_floor, m_up)) m_state = S_MOVE;
                    else if (m_ahead(m_floor, !m_up)) m_up = !m_up;
                    else m_state = S_IDLE;
                end
                S_OPEN: begin
                    if (m_open < LED_W) m_open++;
                    if (m_open == LED_W) begin m_state = S_HOLD; m_hold = 0; end
                end
                S_HOLD: begin
                    if (m_pend[m_floor] || o) begin m_hold = 0; clr[m_floor] = m_pend[m_floor]; end
                    else begin m_hold++; if (m_hold == DOOR_HOLD) m_state = S_CLOSE; end
                end
                default: begin
                    if (o) begin m_state = S_OPEN; clr[m_floor] = 1; end
                    else begin m_open--; if (m_open == 0) m_state = S_IDLE; end
                end
            endcase
        end else begin
            m_cnt++;
        end
        m_pend = (m_pend | c) & ~clr;
        s = model_snap();
        if (s != last_exp) begin
            exp_q.push_back(s);
            exp_e.push_back(e);
            last_exp = s;
        end
    endtask

    task automatic drive_cycle(input logic [FLOORS-1:0] c, input bit o);
        model_edge(c, o, edge_cnt + 1);
        call_req = c;
`ifdef ELEV_OBSTRUCT_EN
        obstruct = o;
`endif
        @(negedge clk);
    endtask

    task automatic monitor();
        snap_t cur, ex;
        int    ee;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = take_snap();
                if (cur != mon_prev) begin
                    mon_prev = cur;
                    check("floor_range", 32'(floor < FW'(FLOORS)), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_change actual=%0h required=no change (edge %0d)", cur, edge_cnt);
                    end else begin
                        ex = exp_q.pop_front();
                        ee = exp_e.pop_front();
                        check("event_edge", edge_cnt, ee);
                        check("event_outputs", 32'(cur), 32'(ex));
                    end
                end
            end
        end
    endtask

    initial begin
        logic [FLOORS-1:0] c;
        bit o, sent, hit;
        rst_a_p = 1; rst1 = 1; call_req = '0; call_req1 = '0;
`ifdef ELEV_OBSTRUCT_EN
        obstruct = 0; obstruct1 = 0;
`endif
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_floor", floor, 0);
        check("rst_izq", izqLed, ONES);
        check("rst_der", derLed, ONES);
        check("rst_pending", pending, 0);
        check("rst_moving", moving, 0);
        check("rst_dir_up", dir_up, 1);

        // One tick per clk: a same-edge call and clear must leave the bit clear.
        rst1 = 0;
        call_req1 = 5'b00001;
        @(negedge clk);
        check("div1_latch", pending1, 5'b00001);
        @(negedge clk);
        check("div1_clear_wins", pending1, 5'b00000);
        check("div1_open_entry_izq", izq1, ONES);
        call_req1 = '0;
        @(negedge clk);
        check("div1_izq_step1", izq1, 5'b11110);
        check("div1_der_step1", der1, 5'b01111);
        repeat (7) @(negedge clk);
        check("div1_close_step1_izq", izq1, 5'b10000);
        check("div1_close_step1_der", der1, 5'b00001);
        repeat (4) @(negedge clk);
        check("div1_closed_izq", izq1, ONES);
        check("div1_closed_der", der1, ONES);
        check("div1_floor", floor1, 0);
        check("div1_moving", moving1, 0);
        check("div1_dir", dir1, 1);

        model_reset();
        last_exp = model_snap();
        mon_prev = take_snap();
        rst_a_p = 0;
        mon_en = 1;

        drive_cycle(5'b00001, 0);
        repeat (70) drive_cycle('0, 0);
        drive_cycle(5'b01000, 0);
        repeat (100) drive_cycle('0, 0);
        drive_cycle(5'b00001, 0);
        repeat (110) drive_cycle('0, 0);
        drive_cycle(5'b10000, 0);
        sent = 0;
        for (int i = 0; i < 260; i++) begin
            if (!sent && m_floor == 2 && m_state == S_MOVE && m_up) begin
                drive_cycle(5'b00001, 0);
                sent = 1;
            end else begin
                drive_cycle('0, 0);
            end
        end
        check("scan_call_issued", 32'(sent), 1);

        for (int i = 0; i < 2500; i++) begin
            c = '0;
            o = 0;
            if ($urandom_range(0, 7) == 0) c[$urandom_range(0, FLOORS - 1)] = 1'b1;
            if ($urandom_range(0, 31) == 0) c[$urandom_range(0, FLOORS - 1)] = 1'b1;
`ifdef ELEV_OBSTRUCT_EN
            o = ($urandom_range(0, 19) == 0);
`endif
            drive_cycle(c, o);
        end

        drive_cycle(FLOORS'(1 << m_floor), 0);
        hit = 0;
        for (int i = 0; i < 600 && !hit; i++) begin
            if (m_state == S_OPEN && m_open >= 2) hit = 1;
            else drive_cycle('0, 0);
        end
        check("reach_mid_open", 32'(hit), 1);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("pre_reset_door_open", 32'(izqLed != ONES), 1);
        mon_en = 0;
        rst_a_p = 1;
        @(negedge clk);
        check("midrst_floor", floor, 0);
        check("midrst_izq", izqLed, ONES);
        check("midrst_der", derLed, ONES);
        check("midrst_pending", pending, 0);
        check("midrst_moving", moving, 0);
        check("midrst_dir_up", dir_up, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
